// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one loadable up-counter
// among N_REQ requesters. The winner's start value is loaded into the
// counter, which then counts up to all-ones, and the owner gets a one-cycle
// done pulse. Dropping the owner's req while loading or counting aborts the
// interval without a done pulse.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req        per-requester request level, held until done or abort
//   req_start  start value of requester i in bits [i*WIDTH +: WIDTH]
//   grant      one-hot owner of the counter, zero when idle
//   done       one-cycle completion pulse to the owner
//   busy       high whenever the FSM is not idle
//   count      current counter value
module counter_sched #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_start,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       count
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   rr_ptr, owner, owner_nxt, sel_idx;
  logic            sel_found;
  logic [WIDTH-1:0] start_q;
  logic            owner_req;
  logic            cnt_max;

  assign owner_req = req[owner];
  assign cnt_max   = (count == '1);
  // Pointer advances past the owner on both completion and abort.
  assign owner_nxt = (owner == PW'(N_REQ-1)) ? '0 : owner + 1'b1;

  // First set req bit searching upward from rr_ptr, wrapping at N_REQ.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!sel_found && req[PW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (sel_found) state_d = LOAD;
      LOAD: state_d = owner_req ? RUN : IDLE;
      RUN: begin
        if (!owner_req)   state_d = IDLE;
        else if (cnt_max) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      start_q <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant   <= N_REQ'(1) << sel_idx;
            owner   <= sel_idx;
            // Start value is sampled only here; later changes are ignored.
            start_q <= req_start[int'(sel_idx)*WIDTH +: WIDTH];
          end
        end
        LOAD: begin
          if (!owner_req) begin
            grant  <= '0;
            rr_ptr <= owner_nxt;
          end else begin
            count <= start_q;
          end
        end
        RUN: begin
          if (!owner_req) begin
            grant  <= '0;
            rr_ptr <= owner_nxt;
          end else if (!cnt_max) begin
            count <= count + 1'b1;   // saturates: never wraps past all-ones
          end
        end
        DONE: begin
          grant  <= '0;
          rr_ptr <= owner_nxt;
        end
        default: grant <= '0;
      endcase
    end
  end

  // Moore decode: done only in DONE, steered to the registered owner.
  assign done = (state == DONE) ? grant : '0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched (N_REQ=2, WIDTH=4). Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_counter_sched;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = '0;
  logic [7:0] req_start = '0;
  logic [1:0] grant, done;
  logic       busy;
  logic [3:0] count;

  int ncmp = 0;
  int nerr = 0;

  counter_sched #(.N_REQ(2), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_start(req_start),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    reset = 1'b1;
    @(negedge clk);
    ncmp++;
    if ({grant, done, busy, count} !== 9'd0) begin
      $display("FAIL reset_state: got grant=%b done=%b busy=%b count=%0d, want all 0",
               grant, done, busy, count);
      nerr++;
    end
    reset = 1'b0;
    tick(2);
    ncmp++;
    if ({grant, busy, count} !== 7'd0) begin
      $display("FAIL idle_no_req: got grant=%b busy=%b count=%0d, want 0", grant, busy, count);
      nerr++;
    end
  endtask

  // s=5: grant after E0, count=5 after E1, 15 after E11, done after E12, idle after E13.
  task automatic test_basic();
    do_reset();
    req_start = {4'd0, 4'd5};
    req = 2'b01;
    tick(1);
    ncmp++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      $display("FAIL basic_grant: got grant=%b busy=%b, want 01 1", grant, busy);
      nerr++;
    end
    tick(1);
    ncmp++;
    if (count !== 4'd5) begin
      $display("FAIL basic_load: got count=%0d, want 5", count);
      nerr++;
    end
    tick(10);
    ncmp++;
    if (count !== 4'd15 || done !== 2'b00) begin
      $display("FAIL basic_e11: got count=%0d done=%b, want 15 00", count, done);
      nerr++;
    end
    tick(1);
    ncmp++;
    if (done !== 2'b01 || grant !== 2'b01 || count !== 4'd15) begin
      $display("FAIL basic_done: got done=%b grant=%b count=%0d, want 01 01 15", done, grant, count);
      nerr++;
    end
    req = 2'b00;
    tick(1);
    ncmp++;
    if (done !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin
      $display("FAIL basic_release: got done=%b grant=%b busy=%b, want 00 00 0", done, grant, busy);
      nerr++;
    end
  endtask

  // Both requesting, start 14: 3 busy cycles after LOAD then DONE, one IDLE cycle between.
  task automatic test_back_to_back();
    logic [1:0] exp_g [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                               2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [1:0] exp_d [11] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00,
                               2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    do_reset();
    req_start = {4'd14, 4'd14};
    req = 2'b11;
    for (int e = 0; e < 11; e++) begin
      tick(1);
      ncmp++;
      if (grant !== exp_g[e] || done !== exp_d[e]) begin
        $display("FAIL b2b_E%0d: got grant=%b done=%b, want %b %b", e, grant, done, exp_g[e], exp_d[e]);
        nerr++;
      end
    end
    req = 2'b00;
  endtask

  // s=15: LOAD, one RUN cycle, DONE after E2; count stays at 15.
  task automatic test_start_max();
    do_reset();
    req_start = {4'd0, 4'd15};
    req = 2'b01;
    tick(2);
    ncmp++;
    if (count !== 4'd15 || done !== 2'b00) begin
      $display("FAIL max_run: got count=%0d done=%b, want 15 00", count, done);
      nerr++;
    end
    tick(1);
    ncmp++;
    if (done !== 2'b01 || count !== 4'd15) begin
      $display("FAIL max_done: got done=%b count=%0d, want 01 15", done, count);
      nerr++;
    end
    req = 2'b00;
    tick(1);
    ncmp++;
    if (count !== 4'd15 || grant !== 2'b00 || done !== 2'b00) begin
      $display("FAIL max_nowrap: got count=%0d grant=%b done=%b, want 15 00 00", count, grant, done);
      nerr++;
    end
  endtask

  // Requester 0 from 0, drop req[0] after E4 (count 3); req[1] pending throughout.
  task automatic test_abort();
    do_reset();
    req_start = {4'd7, 4'd0};
    req = 2'b11;
    for (int e = 0; e < 5; e++) begin
      tick(1);
      ncmp++;
      if (done !== 2'b00 || grant !== 2'b01) begin
        $display("FAIL abort_pre_E%0d: got grant=%b done=%b, want 01 00", e, grant, done);
        nerr++;
      end
    end
    ncmp++;
    if (count !== 4'd3) begin
      $display("FAIL abort_e4_count: got %0d, want 3", count);
      nerr++;
    end
    req = 2'b10;
    tick(1);
    ncmp++;
    if (busy !== 1'b0 || grant !== 2'b00 || done !== 2'b00 || count !== 4'd3) begin
      $display("FAIL abort_idle: got busy=%b grant=%b done=%b count=%0d, want 0 00 00 3",
               busy, grant, done, count);
      nerr++;
    end
    tick(1);
    ncmp++;
    if (grant !== 2'b10 || busy !== 1'b1 || count !== 4'd3) begin
      $display("FAIL abort_next_grant: got grant=%b busy=%b count=%0d, want 10 1 3", grant, busy, count);
      nerr++;
    end
    req = 2'b00;
  endtask

  // Asynchronous reset mid-RUN, then rr_ptr restarts at requester 0.
  task automatic test_async_reset();
    do_reset();
    req_start = {4'd2, 4'd5};
    req = 2'b01;
    tick(4);
    ncmp++;
    if (count !== 4'd7 || busy !== 1'b1) begin
      $display("FAIL areset_pre: got count=%0d busy=%b, want 7 1", count, busy);
      nerr++;
    end
    #1 reset = 1'b1;
    #1;
    ncmp++;
    if ({grant, done, busy, count} !== 9'd0) begin
      $display("FAIL areset_immediate: got grant=%b done=%b busy=%b count=%0d, want all 0",
               grant, done, busy, count);
      nerr++;
    end
    @(negedge clk);
    reset = 1'b0;
    req = 2'b11;
    tick(1);
    ncmp++;
    if (grant !== 2'b01) begin
      $display("FAIL areset_rr: got grant=%b, want 01", grant);
      nerr++;
    end
    req = 2'b00;
  endtask

  // req_start changed to 9 mid-RUN: timing still that of s=5.
  task automatic test_start_change();
    do_reset();
    req_start = {4'd0, 4'd5};
    req = 2'b01;
    tick(2);
    req_start = {4'd0, 4'd9};
    tick(1);
    ncmp++;
    if (count !== 4'd6) begin
      $display("FAIL chg_count: got %0d, want 6", count);
      nerr++;
    end
    tick(8);
    ncmp++;
    if (count !== 4'd14 || done !== 2'b00) begin
      $display("FAIL chg_e10: got count=%0d done=%b, want 14 00", count, done);
      nerr++;
    end
    tick(2);
    ncmp++;
    if (done !== 2'b01) begin
      $display("FAIL chg_done: got done=%b, want 01", done);
      nerr++;
    end
    req = 2'b00;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_max();
    test_abort();
    test_async_reset();
    test_start_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
